// File: rtl/onebc_ctrl_if.sv
// onebc_ctrl_if: program-ROM and datapath bus of the 1-bit computer sequencer.
// master = sequencer side, slave = ROM/datapath side.
interface onebc_ctrl_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] rom_addr_o;
    logic [7:0]      rom_data_i;
    logic            rr_i;
    logic            exec_o;
    logic [3:0]      op_o;
    logic [3:0]      io_addr_o;

    modport master (
        output rom_addr_o, exec_o, op_o, io_addr_o,
        input  rom_data_i, rr_i
    );

    modport slave (
        input  rom_addr_o, exec_o, op_o, io_addr_o,
        output rom_data_i, rr_i
    );
endinterface

// File: rtl/onebc_ctrl.sv
// onebc_ctrl: fetch/decode sequencer for the 1-bit computer.
// Define ONEBC_CTRL_STACK_EN to build the one-entry JSR/RTN return register.
module onebc_ctrl #(
    parameter int PC_W = 8
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         run_i,
    output logic         halt_o,
    onebc_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        OPFETCH,
        OPLOAD,
        HALT
    } state_t;

    localparam logic [PC_W-1:0] ONE = PC_W'(1);
    localparam logic [PC_W-1:0] TWO = PC_W'(2);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            exec_q;
    logic [3:0]      op_q;
    logic [3:0]      addr_q;
    logic            halt_q;

`ifdef ONEBC_CTRL_STACK_EN
    logic [PC_W-1:0] ret_q;
    logic            ret_v;
    logic            jsr_q;
`endif

    logic [3:0] opc;
    logic       is_dp;
    logic       is_skz;
    logic       is_jmp;
    logic       is_rtn;
    logic       is_hlt;

    assign opc    = bus.rom_data_i[7:4];
    assign is_dp  = (opc <= 4'hA);
    assign is_jmp = (opc == 4'hB) || (opc == 4'hC);
    assign is_skz = (opc == 4'hD);
    assign is_rtn = (opc == 4'hE);
    assign is_hlt = (opc == 4'hF);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state  <= IDLE;
            pc     <= '0;
            exec_q <= 1'b0;
            op_q   <= '0;
            addr_q <= '0;
            halt_q <= 1'b0;
`ifdef ONEBC_CTRL_STACK_EN
            ret_q  <= '0;
            ret_v  <= 1'b0;
            jsr_q  <= 1'b0;
`endif
        end else begin
            exec_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (run_i) state <= FETCH;
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    state <= run_i ? FETCH : IDLE;
                    unique case (1'b1)
                        is_dp: begin
                            op_q   <= opc;
                            addr_q <= bus.rom_data_i[3:0];
                            exec_q <= 1'b1;
                            pc     <= pc + ONE;
                        end
                        is_skz: pc <= bus.rr_i ? pc + ONE : pc + TWO;
                        is_jmp: begin
                            pc    <= pc + ONE;
                            state <= OPFETCH;
`ifdef ONEBC_CTRL_STACK_EN
                            jsr_q <= (opc == 4'hB);
`endif
                        end
                        is_rtn: begin
`ifdef ONEBC_CTRL_STACK_EN
                            if (ret_v) begin
                                pc    <= ret_q;
                                ret_v <= 1'b0;
                            end else begin
                                pc <= pc + ONE;
                            end
`else
                            pc <= pc + ONE;
`endif
                        end
                        is_hlt: begin
                            state  <= HALT;
                            halt_q <= 1'b1;
                        end
                    endcase
                end
                OPFETCH: state <= OPLOAD;
                OPLOAD: begin
                    // pc still points at the operand word here
                    pc    <= PC_W'(bus.rom_data_i);
                    state <= run_i ? FETCH : IDLE;
`ifdef ONEBC_CTRL_STACK_EN
                    if (jsr_q) begin
                        ret_q <= pc + ONE;
                        ret_v <= 1'b1;
                    end
`endif
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr_o = pc;
    assign bus.exec_o     = exec_q;
    assign bus.op_o       = op_q;
    assign bus.io_addr_o  = addr_q;
    assign halt_o         = halt_q;

endmodule

// File: tb/tb_onebc_ctrl.sv
// tb_onebc_ctrl: vector table of small programs plus directed timing,
// reset, run-control and PC_W=4 wrap-around sequences.
module tb_onebc_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic rr = 1'b0;
    logic rst4 = 1'b0;
    logic run4 = 1'b0;
    logic halt;
    logic halt4;

    always #5 clk = ~clk;

    onebc_ctrl_if #(.PC_W(8)) bus ();
    onebc_ctrl_if #(.PC_W(4)) bus4 ();

    onebc_ctrl #(.PC_W(8)) dut (
        .clk_i  (clk),
        .arst_ni(rst_n),
        .run_i  (run),
        .halt_o (halt),
        .bus    (bus)
    );

    onebc_ctrl #(.PC_W(4)) dut4 (
        .clk_i  (clk),
        .arst_ni(rst4),
        .run_i  (run4),
        .halt_o (halt4),
        .bus    (bus4)
    );

    logic [7:0] rom_mem [32];
    logic [7:0] rom4 [16];
    logic [7:0] rom_q;
    logic [7:0] rom4_q;

    always @(posedge clk) begin
        rom_q  <= rom_mem[bus.rom_addr_o[4:0]];
        rom4_q <= rom4[bus4.rom_addr_o];
    end

    assign bus.rom_data_i  = rom_q;
    assign bus.rr_i        = rr;
    assign bus4.rom_data_i = rom4_q;
    assign bus4.rr_i       = 1'b0;

    typedef struct packed {
        logic [31:0][7:0] rom;
        logic             rr;
        logic [7:0]       n_ex;
        logic [3:0][7:0]  ex;
        logic [7:0]       halt_pc;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;
    int got_n;
    logic [7:0] got [8];
    logic halted;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_rom(input logic [31:0][7:0] img);
        for (int i = 0; i < 32; i++) rom_mem[i] = img[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
    endtask

    task automatic run_to_halt(input int budget);
        got_n = 0;
        halted = 1'b0;
        for (int c = 0; c < budget && !halted; c++) begin
            @(posedge clk);
            #1;
            if (bus.exec_o) begin
                if (got_n < 8) got[got_n] = {bus.op_o, bus.io_addr_o};
                got_n++;
            end
            halted = halt;
        end
    endtask

    logic [31:0][7:0] img;
    logic [7:0] exp_addr [7];

    initial begin
        for (int i = 0; i < NV; i++) begin
            vecs[i].rom = {32{8'h3F}};
            vecs[i].rr = 1'b0;
            vecs[i].ex = '0;
        end
        // straight-line ops then halt
        vecs[0].rom[0] = 8'h01;
        vecs[0].rom[1] = 8'h72;
        vecs[0].rom[2] = 8'hF0;
        vecs[0].n_ex = 2;
        vecs[0].ex[0] = 8'h01;
        vecs[0].ex[1] = 8'h72;
        vecs[0].halt_pc = 8'h02;
        // JMP
        vecs[1].rom[0] = 8'hC0;
        vecs[1].rom[1] = 8'h10;
        vecs[1].rom[16] = 8'hF0;
        vecs[1].n_ex = 0;
        vecs[1].halt_pc = 8'h10;
        // SKZ taken / not taken
        for (int k = 2; k <= 3; k++) begin
            vecs[k].rom[0] = 8'hD0;
            vecs[k].rom[1] = 8'h03;
            vecs[k].rom[2] = 8'h05;
            vecs[k].rom[3] = 8'hF0;
            vecs[k].halt_pc = 8'h03;
        end
        vecs[2].rr = 1'b0;
        vecs[2].n_ex = 1;
        vecs[2].ex[0] = 8'h05;
        vecs[3].rr = 1'b1;
        vecs[3].n_ex = 2;
        vecs[3].ex[0] = 8'h03;
        vecs[3].ex[1] = 8'h05;
        // JSR / RTN
        vecs[4].rom[0] = 8'hB0;
        vecs[4].rom[1] = 8'h08;
        vecs[4].rom[2] = 8'hF0;
        vecs[4].rom[8] = 8'h01;
        vecs[4].rom[9] = 8'hE0;
        vecs[4].rom[10] = 8'hF0;
        vecs[4].n_ex = 1;
        vecs[4].ex[0] = 8'h01;
`ifdef ONEBC_CTRL_STACK_EN
        vecs[4].halt_pc = 8'h02;
`else
        vecs[4].halt_pc = 8'h0A;
`endif
        for (int i = 0; i < 16; i++) rom4[i] = {4'h2, i[3:0]};

        load_rom(vecs[0].rom);
        #1;
        check("rst_addr", 32'(bus.rom_addr_o), 0);
        check("rst_exec", 32'(bus.exec_o), 0);
        check("rst_op", 32'(bus.op_o), 0);
        check("rst_io", 32'(bus.io_addr_o), 0);
        check("rst_halt", 32'(halt), 0);

        for (int v = 0; v < NV; v++) begin
            load_rom(vecs[v].rom);
            rr = vecs[v].rr;
            do_reset();
            run_to_halt(100);
            check($sformatf("v%0d_halted", v), 32'(halted), 1);
            check($sformatf("v%0d_nexec", v), got_n, 32'(vecs[v].n_ex));
            for (int e = 0; e < int'(vecs[v].n_ex) && e < got_n; e++)
                check($sformatf("v%0d_exec%0d", v, e), 32'(got[e]),
                      32'(vecs[v].ex[e]));
            check($sformatf("v%0d_haltpc", v), 32'(bus.rom_addr_o),
                  32'(vecs[v].halt_pc));
        end
        rr = 1'b0;

        // first exec_o timing and halt persistence
        load_rom(vecs[0].rom);
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("t1_exec_c%0d", c), 32'(bus.exec_o),
                  32'(c == 3));
        end
        run_to_halt(20);
        check("t1_halted", 32'(halted), 1);
        begin
            int bad = 0;
            for (int c = 0; c < 20; c++) begin
                run = c[0];
                @(posedge clk);
                #1;
                if (bus.rom_addr_o != 8'h02 || !halt || bus.exec_o) bad++;
            end
            check("t1_halt_hold", bad, 0);
        end

        // JMP address sequence and latency
        exp_addr = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h10, 8'h10, 8'h10};
        load_rom(vecs[1].rom);
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("jmp_addr_c%0d", c), 32'(bus.rom_addr_o),
                  32'(exp_addr[c-1]));
            check($sformatf("jmp_halt_c%0d", c), 32'(halt), 32'(c == 7));
        end

        // async reset in OPFETCH
        img = {32{8'h3F}};
        img[0] = 8'h35;
        img[1] = 8'hC0;
        img[2] = 8'h08;
        img[8] = 8'hF0;
        load_rom(img);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        check("ar_pre_addr", 32'(bus.rom_addr_o), 2);
        check("ar_pre_op", 32'({bus.op_o, bus.io_addr_o}), 32'h35);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_addr", 32'(bus.rom_addr_o), 0);
        check("ar_op", 32'(bus.op_o), 0);
        check("ar_io", 32'(bus.io_addr_o), 0);
        check("ar_exec", 32'(bus.exec_o), 0);
        check("ar_halt", 32'(halt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_to_halt(40);
        check("ar_halted", 32'(halted), 1);
        check("ar_nexec", got_n, 1);
        check("ar_haltpc", 32'(bus.rom_addr_o), 8);

        // run_i dropped in OPFETCH
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        run = 1'b0;
        begin
            int ex = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                if (bus.exec_o) ex++;
            end
            check("rd_no_exec", ex, 0);
        end
        check("rd_idle_addr", 32'(bus.rom_addr_o), 8);
        check("rd_idle_halt", 32'(halt), 0);
        run = 1'b1;
        run_to_halt(10);
        check("rd_halted", 32'(halted), 1);
        check("rd_haltpc", 32'(bus.rom_addr_o), 8);

        // PC_W=4 wrap-around, back-to-back exec pulses
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        run4 = 1'b1;
        begin
            int k = 0;
            int last = 0;
            for (int c = 1; c <= 50 && k < 20; c++) begin
                @(posedge clk);
                #1;
                if (bus4.exec_o) begin
                    check($sformatf("wrap_addr%0d", k),
                          32'(bus4.io_addr_o), 32'(k % 16));
                    check($sformatf("wrap_op%0d", k), 32'(bus4.op_o), 2);
                    if (k > 0) check($sformatf("wrap_gap%0d", k), c - last, 2);
                    last = c;
                    k++;
                end
            end
            check("wrap_count", k, 20);
        end
        run4 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
